dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 14, sets the memory word-address width.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req0/req1  in  1  access request from port 0 (CPU) / port 1 (loader).
REQ-005 we0/we1  in  1  1 = store, 0 = load.
REQ-006 size0/size1  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-007 addr0/addr1  in  32  byte address.
REQ-008 wdata0/wdata1  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 gnt0/gnt1  out  1  one-cycle pulse: the request was accepted this cycle.
REQ-010 done0/done1  out  1  one-cycle pulse: the access completed.
REQ-011 err0/err1  out  1  valid with done: the access was misaligned and not performed.
REQ-012 rdata  out  32  load data, right-shifted by byte offset and zero-filled above; valid while any done is high.
REQ-013 mem_we  out  1  memory write enable.
REQ-014 mem_addr  out  AW  memory word address.
REQ-015 mem_din  out  32  memory write word.
REQ-016 mem_dout  in  32  memory read word; valid the cycle after mem_addr is presented with mem_we=0.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, CAPTURE, MERGE_WR and RESP; only one access is in flight at a time.
REQ-018 IDLE: if any req is high, pulse the winner's gnt, latch its we/size/addr/wdata and port id, and go to ACCESS; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: with both req high, the port not granted last wins; a single requester always wins.
REQ-020 Requests SHALL NOT be granted in any state other than IDLE; a requester holds req and its fields stable until gnt.
REQ-021 Misaligned means half with addr[0]=1, or word with addr[1:0]!=0; such an access goes ACCESS->RESP with mem_we=0 and err=1.
REQ-022 ACCESS: mem_addr = latched addr[AW+1:2]; mem_we=1 with mem_din=wdata only for an aligned word store, which then goes to RESP; loads and byte/half stores go to CAPTURE.
REQ-023 CAPTURE (mem_addr held): a load registers rdata = mem_dout >> (8*addr[1:0]), masked to 8/16/32 bits by size, then goes to RESP.
REQ-024 CAPTURE for a byte/half store: register a merge word equal to mem_dout with the addressed lanes replaced by wdata, then go to MERGE_WR.
REQ-025 MERGE_WR: mem_we=1, mem_din = merge word, mem_addr held; next state RESP.
REQ-026 RESP: pulse done (and err if flagged) on the latched port only; next state IDLE.
REQ-027 Cycle timing with grant at cycle T: word store done at T+2, load done at T+3, byte/half store done at T+4, misaligned access done at T+2.
REQ-028 rdata SHALL hold its last value outside RESP; stores do not modify rdata.
REQ-029 mem_we SHALL be 0 in every state other than ACCESS (word store) and MERGE_WR.
REQ-030 Address bits above AW+1 are ignored, so addresses alias modulo 2^(AW+2) bytes.
REQ-031 req dropping after gnt SHALL NOT affect the in-flight access.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, all gnt/done/err/mem_we to 0, mem_addr, mem_din and rdata to 0, and the round-robin pointer to "port 1 last", so port 0 wins the first tie.
REQ-033 Reset during any state SHALL abandon the access with no done, and no memory write after rst_n falls.
REQ-034 Operation SHALL resume on the first clk edge with rst_n high.

Verification
REQ-035 Word store then load: port 0 stores 0xDEADBEEF at 0x10, then loads word 0x10 -> mem write at T+1 with mem_addr=4; load done at T+3 with rdata=0xDEADBEEF.
REQ-036 Byte RMW: memory word 4 = 0x11223344; port 1 stores byte 0xAA at 0x12 -> mem_we at T+3 with mem_din=0x11AA3344 and done1 at T+4; a later lbu at 0x12 returns 0x000000AA.
REQ-037 Contention: req0 and req1 held high for 4 grants after reset -> grant order 0,1,0,1 and each port's done only on its own lines.
REQ-038 Misaligned: port 0 loads a half at 0x13 -> done0=err0=1 at T+2, mem_we never asserted, rdata unchanged.
REQ-039 Reset mid-RMW: rst_n low during CAPTURE of a byte store -> mem_we stays 0, no done, memory word unchanged, and the next request is granted from IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter for one word-wide synchronous data memory with byte/half read-modify-write
module dmem_arbiter #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [1:0]    size0,
    input  logic [31:0]   addr0,
    input  logic [31:0]   wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [1:0]    size1,
    input  logic [31:0]   addr1,
    input  logic [31:0]   wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic [31:0]   rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    input  logic [31:0]   mem_dout
);
    typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, MERGE_WR, RESP} state_t;
    state_t      state;
    logic        we_q, port_q, last_q, sel, mis;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, merge_q, rd_q, lane_mask, merge, load_val;
    logic [4:0]  sh;
    logic        addr_unused;
    assign addr_unused = ^{addr0[31:AW+2], addr1[31:AW+2], addr_q[31:AW+2]};
    // Winner: port 1 if it alone requests, or on a tie when port 0 was granted last
    assign sel = req1 & (~req0 | ~last_q);
    assign mis = (size_q == 2'b01 & addr_q[0]) | (size_q[1] & |addr_q[1:0]);
    assign sh = {addr_q[1:0], 3'b000};
    assign lane_mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    assign merge = (mem_dout & ~lane_mask) | ((wdata_q << sh) & lane_mask);
    assign load_val = (mem_dout >> sh) & (size_q == 2'b00 ? 32'h0000_00ff :
                                          size_q == 2'b01 ? 32'h0000_ffff : 32'hffff_ffff);
    // Access FSM; every output is registered so it appears one cycle after the state that produces it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_q   <= 1'b1;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rd_q     <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rdata    <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: if (req0 | req1) begin
                    gnt0     <= ~sel;
                    gnt1     <= sel;
                    last_q   <= sel;
                    port_q   <= sel;
                    we_q     <= sel ? we1 : we0;
                    size_q   <= sel ? size1 : size0;
                    addr_q   <= sel ? addr1 : addr0;
                    wdata_q  <= sel ? wdata1 : wdata0;
                    mem_addr <= sel ? addr1[AW+1:2] : addr0[AW+1:2];
                    state    <= ACCESS;
                end
                ACCESS: if (mis) begin
                    state <= RESP;
                end else if (we_q & size_q[1]) begin
                    mem_we  <= 1'b1;
                    mem_din <= wdata_q;
                    state   <= RESP;
                end else begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    rd_q    <= load_val;
                    merge_q <= merge;
                    state   <= we_q ? MERGE_WR : RESP;
                end
                MERGE_WR: begin
                    mem_we  <= 1'b1;
                    mem_din <= merge_q;
                    state   <= RESP;
                end
                RESP: begin
                    done0 <= ~port_q;
                    done1 <= port_q;
                    err0  <= ~port_q & mis;
                    err1  <= port_q & mis;
                    rdata <= (~we_q & ~mis) ? rd_q : rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
